// File: rtl/stream_header_framer.sv
// ---------------------------------------------------------------------------
// stream_header_framer
//
// Buffers a valid/ready sample stream in a small FIFO and re-emits it as
// framed packets: HDR_LEN header words, the payload words, then an optional
// checksum trailer (sum of the payload words, modulo 2^W).
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (synchronous release expected)
//   s_data   : input payload word
//   s_valid  : input word valid
//   s_last   : input word is the final payload word of its frame
//   s_ready  : FIFO can accept a word this cycle
//   m_data   : framed output word
//   m_valid  : output word valid
//   m_ready  : downstream accepts the output word
//   m_sof    : output word is the first header word of a frame
//   m_last   : output word is the final word of a frame
//   len_err  : one-cycle pulse when a frame is force-closed at MAX_LEN
// ---------------------------------------------------------------------------
module stream_header_framer #(
    parameter int           W          = 16,
    parameter int           HDR_LEN    = 3,
    parameter logic [W-1:0] HDR_WORD   = W'(16'hFFFF),
    parameter int           FIFO_DEPTH = 8,
    parameter int           MAX_LEN    = 1024,
    parameter bit           TRAILER_EN = 1'b1,
    parameter bit           SEQ_EN     = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_sof,
    output logic         m_last,
    output logic         len_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [3:0]    HDR_LAST = 4'(HDR_LEN - 1);
    localparam logic [LW-1:0] PAY_LAST = LW'(MAX_LEN - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TRL  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Payload FIFO: each entry stores {last, data}
    // ------------------------------------------------------------------
    logic [W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          ready_reg;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [W:0]    head;

    // Framer state and output register
    state_t        state_reg;
    logic [3:0]    hdr_idx_reg;
    logic [LW-1:0] pay_cnt_reg;
    logic [W-1:0]  csum_reg;
    logic [W-1:0]  seq_reg;
    logic [W-1:0]  m_data_reg;
    logic          m_valid_reg;
    logic          m_sof_reg;
    logic          m_last_reg;
    logic          len_err_reg;

    logic          load_en;
    logic          at_max;
    logic          frame_end;
    logic [W-1:0]  hdr_word;

    // Full is judged on the registered count only, so a pop in the same
    // cycle never frees a slot for a simultaneous write.
    assign push       = s_valid && ready_reg;
    assign fifo_empty = (count_reg == '0);
    assign head       = mem[rd_ptr_reg];

    // The output register takes a new word whenever it is empty or its
    // current word is being consumed.
    assign load_en = !m_valid_reg || m_ready;
    assign pop     = (state_reg == PAY) && load_en && !fifo_empty;

    assign at_max    = (pay_cnt_reg == PAY_LAST);
    assign frame_end = head[W] || at_max;

    // With SEQ_EN the final header word carries the frame sequence number.
    assign hdr_word = (SEQ_EN && (hdr_idx_reg == HDR_LAST)) ? seq_reg : HDR_WORD;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Storage array carries no reset; flushing is done through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            ready_reg <= (count_next != FULL_CNT);
        end
    end

    // ------------------------------------------------------------------
    // Framer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            hdr_idx_reg <= '0;
            pay_cnt_reg <= '0;
            csum_reg    <= '0;
            seq_reg     <= '0;
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
            m_sof_reg   <= 1'b0;
            m_last_reg  <= 1'b0;
            len_err_reg <= 1'b0;
        end else begin
            len_err_reg <= 1'b0;

            if (m_valid_reg && m_ready && m_last_reg) begin
                seq_reg <= seq_reg + W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (load_en) begin
                        m_valid_reg <= 1'b0;
                        m_sof_reg   <= 1'b0;
                        m_last_reg  <= 1'b0;
                    end
                    hdr_idx_reg <= '0;
                    pay_cnt_reg <= '0;
                    csum_reg    <= '0;
                    if (!fifo_empty) begin
                        state_reg <= HDR;
                    end
                end

                HDR: begin
                    if (load_en) begin
                        m_valid_reg <= 1'b1;
                        m_data_reg  <= hdr_word;
                        m_sof_reg   <= (hdr_idx_reg == 4'd0);
                        m_last_reg  <= 1'b0;
                        if (hdr_idx_reg == HDR_LAST) begin
                            state_reg <= PAY;
                        end else begin
                            hdr_idx_reg <= hdr_idx_reg + 4'd1;
                        end
                    end
                end

                PAY: begin
                    if (load_en) begin
                        if (!fifo_empty) begin
                            m_valid_reg <= 1'b1;
                            m_data_reg  <= head[W-1:0];
                            m_sof_reg   <= 1'b0;
                            csum_reg    <= csum_reg + head[W-1:0];
                            pay_cnt_reg <= pay_cnt_reg + LW'(1);
                            if (frame_end) begin
                                m_last_reg <= !TRAILER_EN;
                                // Only a close caused by the length limit is an error.
                                len_err_reg <= !head[W];
                                if (TRAILER_EN) begin
                                    state_reg <= TRL;
                                end else begin
                                    state_reg <= IDLE;
                                end
                            end else begin
                                m_last_reg <= 1'b0;
                            end
                        end else begin
                            // Upstream starved: bubble, frame stays open.
                            m_valid_reg <= 1'b0;
                            m_sof_reg   <= 1'b0;
                            m_last_reg  <= 1'b0;
                        end
                    end
                end

                TRL: begin
                    if (load_en) begin
                        m_valid_reg <= 1'b1;
                        m_data_reg  <= csum_reg;
                        m_sof_reg   <= 1'b0;
                        m_last_reg  <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign s_ready = ready_reg;
    assign m_data  = m_data_reg;
    assign m_valid = m_valid_reg;
    assign m_sof   = m_sof_reg;
    assign m_last  = m_last_reg;
    assign len_err = len_err_reg;

endmodule

// File: tb/tb_stream_header_framer.sv
// ---------------------------------------------------------------------------
// tb_stream_header_framer
//
// Two framer instances share one stimulus/monitor path selected by 'sel':
//   A (sel=0): W=16, HDR_LEN=3, MAX_LEN=1024, TRAILER_EN=1, SEQ_EN=0
//   B (sel=1): W=16, HDR_LEN=3, MAX_LEN=8,    TRAILER_EN=1, SEQ_EN=1
// Directed frames come from a vector table; random frames are checked
// against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_stream_header_framer;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } in_t;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        last;
    } beat_t;

    typedef struct {
        int          tid;
        bit          has_in;
        logic [15:0] in_data;
        bit          in_last;
        logic [15:0] exp_data;
        bit          exp_sof;
        bit          exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sel = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;

    logic        s_ready, m_valid, m_sof, m_last, len_err;
    logic [15:0] m_data;

    logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_sof, a_m_last, a_len_err;
    logic [15:0] a_m_data;
    logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_sof, b_m_last, b_len_err;
    logic [15:0] b_m_data;

    int checks = 0;
    int errors = 0;

    in_t   in_q[$];
    beat_t exp_q[$];
    beat_t act_q[$];
    vec_t  vt[$];
    int    lerr_cnt = 0;
    int    exp_lerr = 0;
    int    model_seq = 0;

    always #5 clk = ~clk;

    assign a_s_valid = s_valid && !sel;
    assign b_s_valid = s_valid && sel;
    assign a_m_ready = m_ready && !sel;
    assign b_m_ready = m_ready && sel;
    assign s_ready   = sel ? b_s_ready : a_s_ready;
    assign m_valid   = sel ? b_m_valid : a_m_valid;
    assign m_data    = sel ? b_m_data  : a_m_data;
    assign m_sof     = sel ? b_m_sof   : a_m_sof;
    assign m_last    = sel ? b_m_last  : a_m_last;
    assign len_err   = sel ? b_len_err : a_len_err;

    stream_header_framer #(
        .W(16), .HDR_LEN(3), .HDR_WORD(16'hFFFF), .FIFO_DEPTH(8),
        .MAX_LEN(1024), .TRAILER_EN(1'b1), .SEQ_EN(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(a_s_valid), .s_last(s_last), .s_ready(a_s_ready),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .m_sof(a_m_sof), .m_last(a_m_last), .len_err(a_len_err)
    );

    stream_header_framer #(
        .W(16), .HDR_LEN(3), .HDR_WORD(16'hFFFF), .FIFO_DEPTH(8),
        .MAX_LEN(8), .TRAILER_EN(1'b1), .SEQ_EN(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(b_s_valid), .s_last(s_last), .s_ready(b_s_ready),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_sof(b_m_sof), .m_last(b_m_last), .len_err(b_len_err)
    );

    // Output monitor: collects transfers, counts len_err pulses and checks
    // that a stalled word is held unchanged.
    logic        stall_prev = 1'b0;
    beat_t       held_prev;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(m_valid && m_data == held_prev.data && m_sof == held_prev.sof &&
                      m_last == held_prev.last)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h sof=%b last=%b, need valid=1 data=%h sof=%b last=%b",
                             m_valid, m_data, m_sof, m_last, held_prev.data, held_prev.sof, held_prev.last);
                end
            end
            if (m_valid && m_ready) act_q.push_back('{m_data, m_sof, m_last});
            if (len_err) lerr_cnt++;
            stall_prev = m_valid && !m_ready;
            held_prev  = '{m_data, m_sof, m_last};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_vec(int tid, bit has_in, logic [15:0] d, bit l,
                                    logic [15:0] ed, bit es, bit el);
        vt.push_back('{tid, has_in, d, l, ed, es, el});
    endfunction

    // Frame-level reference: split the input into frames (on last or at
    // max_len words), wrap each with 3 header words and a sum trailer.
    function automatic void model(int max_len, bit seq_en);
        int          i;
        int          n;
        logic [15:0] sum;
        bit          closed;
        in_t         pay[$];
        exp_q.delete();
        exp_lerr = 0;
        i = 0;
        while (i < in_q.size()) begin
            pay.delete();
            n = 0;
            sum = '0;
            closed = 0;
            while (!closed) begin
                pay.push_back(in_q[i]);
                sum = sum + in_q[i].data;
                n++;
                if (in_q[i].last) closed = 1;
                else if (n == max_len) begin
                    closed = 1;
                    exp_lerr++;
                end
                i++;
                if (i >= in_q.size()) closed = 1;
            end
            for (int h = 0; h < 3; h++)
                exp_q.push_back('{(seq_en && h == 2) ? 16'(model_seq) : 16'hFFFF, h == 0, 1'b0});
            foreach (pay[k]) exp_q.push_back('{pay[k].data, 1'b0, 1'b0});
            exp_q.push_back('{sum, 1'b0, 1'b1});
            model_seq++;
        end
    endfunction

    // ready_mode: 0 always ready, 1 toggle 1,0,1,0..., 2 random
    // valid_mode: 0 continuous, 1 random gaps
    task automatic drive(input int start_idx, input int ready_mode, input int valid_mode,
                         input int n_expect, input int budget);
        int idx = start_idx;
        int cyc = 0;
        while ((idx < in_q.size() || act_q.size() < n_expect) && cyc < budget) begin
            if (idx < in_q.size()) begin
                s_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                s_data  = in_q[idx].data;
                s_last  = in_q[idx].last;
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            wait_edge();
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        chk("drive_timeout", 32'(cyc >= budget), 32'd0);
        repeat (4) wait_edge();
    endtask

    task automatic compare_stream(input string name);
        int n;
        chk({name, "_beat_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("%s beat %0d: data=%h sof=%b last=%b", name, i,
                     act_q[i].data, act_q[i].sof, act_q[i].last);
            chk({name, "_beat"}, 32'(act_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic run_table(input int tid, input int ready_mode, input int exp_lerr_n,
                             input string name);
        in_q.delete();
        exp_q.delete();
        act_q.delete();
        lerr_cnt = 0;
        foreach (vt[i]) begin
            if (vt[i].tid == tid) begin
                if (vt[i].has_in) in_q.push_back('{vt[i].in_data, vt[i].in_last});
                exp_q.push_back('{vt[i].exp_data, vt[i].exp_sof, vt[i].exp_last});
            end
        end
        drive(0, ready_mode, 0, exp_q.size(), 400);
        compare_stream(name);
        chk({name, "_len_err_pulses"}, lerr_cnt, exp_lerr_n);
    endtask

    task automatic run_random(input int nframes, input int maxlen_in, input int max_len,
                              input bit seq_en, input string name);
        int L;
        in_q.delete();
        act_q.delete();
        lerr_cnt = 0;
        repeat (nframes) begin
            L = $urandom_range(1, maxlen_in);
            for (int k = 0; k < L; k++) in_q.push_back('{16'($urandom), k == L - 1});
        end
        model(max_len, seq_en);
        drive(0, 2, 1, exp_q.size(), 3000);
        compare_stream(name);
        chk({name, "_len_err_pulses"}, lerr_cnt, exp_lerr);
    endtask

    initial begin
        int idx;
        int cyc;
        int b_seq;

        // tid 1: 4-word frame on A
        add_vec(1, 1, 16'h0001, 0, 16'hFFFF, 1, 0);
        add_vec(1, 1, 16'h0002, 0, 16'hFFFF, 0, 0);
        add_vec(1, 1, 16'h0003, 0, 16'hFFFF, 0, 0);
        add_vec(1, 1, 16'h0004, 1, 16'h0001, 0, 0);
        add_vec(1, 0, 16'h0000, 0, 16'h0002, 0, 0);
        add_vec(1, 0, 16'h0000, 0, 16'h0003, 0, 0);
        add_vec(1, 0, 16'h0000, 0, 16'h0004, 0, 0);
        add_vec(1, 0, 16'h0000, 0, 16'h000A, 0, 1);
        // tid 4: two 2-word frames on B, seq in header word 3
        add_vec(4, 1, 16'h0010, 0, 16'hFFFF, 1, 0);
        add_vec(4, 1, 16'h0020, 1, 16'hFFFF, 0, 0);
        add_vec(4, 1, 16'h0030, 0, 16'h0000, 0, 0);
        add_vec(4, 1, 16'h0040, 1, 16'h0010, 0, 0);
        add_vec(4, 0, 16'h0000, 0, 16'h0020, 0, 0);
        add_vec(4, 0, 16'h0000, 0, 16'h0030, 0, 1);
        add_vec(4, 0, 16'h0000, 0, 16'hFFFF, 1, 0);
        add_vec(4, 0, 16'h0000, 0, 16'hFFFF, 0, 0);
        add_vec(4, 0, 16'h0000, 0, 16'h0001, 0, 0);
        add_vec(4, 0, 16'h0000, 0, 16'h0030, 0, 0);
        add_vec(4, 0, 16'h0000, 0, 16'h0040, 0, 0);
        add_vec(4, 0, 16'h0000, 0, 16'h0070, 0, 1);
        // tid 5: 10 words, last on 10, MAX_LEN=8 on B (seq continues at 2)
        for (int k = 1; k <= 10; k++) add_vec(5, 1, 16'(k), k == 10, 16'h0000, 0, 0);
        vt[vt.size() - 10].exp_data = 16'hFFFF;
        vt[vt.size() - 10].exp_sof  = 1;
        vt[vt.size() - 9].exp_data  = 16'hFFFF;
        vt[vt.size() - 8].exp_data  = 16'h0002;
        for (int k = 1; k <= 7; k++) vt[vt.size() - 8 + k].exp_data = 16'(k);
        add_vec(5, 0, 16'h0000, 0, 16'h0008, 0, 0);
        add_vec(5, 0, 16'h0000, 0, 16'h0024, 0, 1);
        add_vec(5, 0, 16'h0000, 0, 16'hFFFF, 1, 0);
        add_vec(5, 0, 16'h0000, 0, 16'hFFFF, 0, 0);
        add_vec(5, 0, 16'h0000, 0, 16'h0003, 0, 0);
        add_vec(5, 0, 16'h0000, 0, 16'h0009, 0, 0);
        add_vec(5, 0, 16'h0000, 0, 16'h000A, 0, 0);
        add_vec(5, 0, 16'h0000, 0, 16'h0013, 0, 1);

        // Reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_edge();
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_sof", m_sof, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_len_err", len_err, 0);
        chk("reset_m_data", m_data, 16'h0000);
        chk("reset_s_ready", s_ready, 1);

        // Latency: one-word frame accepted at edge E
        s_valid = 1'b1; s_data = 16'h0055; s_last = 1'b1; m_ready = 1'b1;
        wait_edge();                      // E
        s_valid = 1'b0; s_last = 1'b0;
        chk("lat_e0_valid", m_valid, 0);
        wait_edge();                      // E+1
        chk("lat_e1_valid", m_valid, 0);
        wait_edge();                      // E+2
        chk("lat_e2_hdr0", {m_valid, m_sof, m_data}, {1'b1, 1'b1, 16'hFFFF});
        repeat (3) wait_edge();           // E+5
        chk("lat_e5_pay0", {m_valid, m_sof, m_last, m_data}, {3'b100, 16'h0055});
        wait_edge();                      // E+6
        chk("lat_e6_trl", {m_valid, m_last, m_data}, {2'b11, 16'h0055});
        wait_edge();                      // E+7
        chk("lat_e7_idle", m_valid, 0);
        act_q.delete();

        // Directed frame, always ready, then with m_ready toggling
        run_table(1, 0, 0, "t1");
        run_table(1, 1, 0, "t2");

        // Backpressure: 10 words into an 8-deep FIFO with m_ready low
        in_q.delete();
        act_q.delete();
        lerr_cnt = 0;
        for (int k = 0; k < 10; k++) in_q.push_back('{16'h0100 + 16'(k), k == 9});
        m_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (idx < 10) begin
                s_valid = 1'b1; s_data = in_q[idx].data; s_last = in_q[idx].last;
            end else s_valid = 1'b0;
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            wait_edge();
        end
        chk("t3_accepted_while_stalled", idx, 8);
        chk("t3_s_ready_full", s_ready, 0);
        chk("t3_no_transfer", act_q.size(), 0);
        model_seq = 0;
        model(1024, 0);
        drive(idx, 0, 0, exp_q.size(), 400);
        compare_stream("t3");
        chk("t3_len_err_pulses", lerr_cnt, 0);

        // Reset in the middle of a payload
        in_q.delete();
        act_q.delete();
        for (int k = 0; k < 6; k++) in_q.push_back('{16'h0A00 + 16'(k), 1'b0});
        idx = 0;
        cyc = 0;
        m_ready = 1'b1;
        while (act_q.size() < 5 && cyc < 60) begin
            if (idx < 6) begin
                s_valid = 1'b1; s_data = in_q[idx].data; s_last = 1'b0;
            end else s_valid = 1'b0;
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            wait_edge();
            cyc++;
        end
        chk("t6_reached_payload", 32'(act_q.size() >= 5), 32'd1);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_in_reset", m_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_edge();
        chk("t6_s_ready_after_release", s_ready, 1);
        chk("t6_valid_after_release", m_valid, 0);
        run_table(1, 0, 0, "t6");

        // Instance B: sequence numbers and length limit
        sel = 1'b1;
        wait_edge();
        run_table(4, 0, 0, "t4");
        run_table(5, 0, 1, "t5");
        b_seq = 4;

        // Random traffic on A, then on B
        sel = 1'b0;
        wait_edge();
        model_seq = 0;
        run_random(10, 12, 1024, 0, "rnd_a");
        sel = 1'b1;
        wait_edge();
        model_seq = b_seq;
        run_random(10, 20, 8, 1, "rnd_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
